// File: rtl/axi_line_mem.sv
// Line-burst AXI-style memory responder: one AR/R or AW/W/B burst at a time, read/write alternation.
// Optional AXI_LINE_MEM_STALL_EN adds LFSR-driven stalls on R beats and W acceptance.
module axi_line_mem #(
  parameter int unsigned BYTES_PER_LINE = 64,
  parameter int unsigned MEM_LINES      = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [63:0] s_axi_rdata,
  output logic        s_axi_rvalid,
  output logic        s_axi_rlast,
  input  logic        s_axi_rready,
  input  logic [63:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [63:0] s_axi_wdata,
  input  logic        s_axi_wvalid,
  input  logic        s_axi_wlast,
  output logic        s_axi_wready,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready
);

  localparam int unsigned BEATS    = BYTES_PER_LINE / 8;
  localparam int unsigned WORD_IDX = $clog2(MEM_LINES * BEATS);
  localparam int unsigned Depth    = MEM_LINES * BEATS;
  localparam int unsigned OffW     = $clog2(BYTES_PER_LINE);
  localparam int unsigned BeatW    = $clog2(BEATS);
  localparam int unsigned LineW    = WORD_IDX - BeatW;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(BEATS - 1);

  typedef enum logic [1:0] {StIdle, StRBeat, StWBeat, StBResp} state_e;

  state_e             state_q, state_d;
  logic [BeatW-1:0]   beat_q, beat_d;
  logic [LineW-1:0]   line_q, line_d;
  logic               last_was_write_q, last_was_write_d;
  logic               rvalid_q, rvalid_d;
  logic [63:0]        rdata_q;
  logic               rd_en, wr_en;
  logic [LineW-1:0]   rd_line;
  logic [BeatW-1:0]   rd_beat;
  logic               grant_r, grant_w, wready_int, stall;
  logic [LineW-1:0]   ar_line, aw_line;
  logic [63:0]        mem [Depth];

  // Upper address bits wrap by construction.
  assign ar_line = s_axi_araddr[WORD_IDX+2:OffW];
  assign aw_line = s_axi_awaddr[WORD_IDX+2:OffW];

  logic unused_addr;
  assign unused_addr = ^{s_axi_araddr[63:WORD_IDX+3], s_axi_araddr[OffW-1:0],
                         s_axi_awaddr[63:WORD_IDX+3], s_axi_awaddr[OffW-1:0]};

`ifdef AXI_LINE_MEM_STALL_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end
  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  assign grant_r    = s_axi_arvalid && (!s_axi_awvalid || last_was_write_q);
  assign grant_w    = s_axi_awvalid && (!s_axi_arvalid || !last_was_write_q);
  assign wready_int = (state_q == StWBeat) && !stall;

  always_comb begin
    state_d          = state_q;
    beat_d           = beat_q;
    line_d           = line_q;
    last_was_write_d = last_was_write_q;
    rvalid_d         = rvalid_q;
    rd_en            = 1'b0;
    rd_line          = line_q;
    rd_beat          = beat_q;
    wr_en            = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_r) begin
          state_d  = StRBeat;
          line_d   = ar_line;
          beat_d   = '0;
          rd_line  = ar_line;
          rd_beat  = '0;
          rd_en    = !stall;
          rvalid_d = !stall;
        end else if (grant_w) begin
          state_d = StWBeat;
          line_d  = aw_line;
          beat_d  = '0;
        end
      end
      StRBeat: begin
        if (rvalid_q) begin
          if (s_axi_rready) begin
            if (beat_q == LastBeat) begin
              state_d          = StIdle;
              rvalid_d         = 1'b0;
              last_was_write_d = 1'b0;
            end else begin
              // Prefetch the next beat so a held rready streams one beat per cycle.
              beat_d   = beat_q + BeatW'(1);
              rd_beat  = beat_q + BeatW'(1);
              rd_en    = !stall;
              rvalid_d = !stall;
            end
          end
        end else if (!stall) begin
          rd_en    = 1'b1;
          rvalid_d = 1'b1;
        end
      end
      StWBeat: begin
        if (s_axi_wvalid && wready_int) begin
          wr_en = 1'b1;
          if (s_axi_wlast || beat_q == LastBeat) begin
            state_d = StBResp;
          end else begin
            beat_d = beat_q + BeatW'(1);
          end
        end
      end
      StBResp: begin
        if (s_axi_bready) begin
          state_d          = StIdle;
          last_was_write_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= StIdle;
      beat_q           <= '0;
      line_q           <= '0;
      last_was_write_q <= 1'b1;
      rvalid_q         <= 1'b0;
      rdata_q          <= '0;
    end else begin
      state_q          <= state_d;
      beat_q           <= beat_d;
      line_q           <= line_d;
      last_was_write_q <= last_was_write_d;
      rvalid_q         <= rvalid_d;
      if (rd_en) rdata_q <= mem[{rd_line, rd_beat}];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[{line_q, beat_q}] <= s_axi_wdata;
  end

  // Readies are forced low while reset is held so every output reads 0.
  assign s_axi_arready = reset && (state_q == StIdle) && grant_r;
  assign s_axi_awready = reset && (state_q == StIdle) && grant_w;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rvalid_q && (beat_q == LastBeat);
  assign s_axi_rdata   = rdata_q;
  assign s_axi_wready  = wready_int;
  assign s_axi_bvalid  = (state_q == StBResp);

endmodule

// File: tb/tb_axi_line_mem.sv
// Scoreboard bench for axi_line_mem: directed bursts queue expected R/B responses, a monitor checks them.
module tb_axi_line_mem;

  localparam int BPL = 64;
  localparam int ML  = 256;
  localparam int NB  = 8;

  logic        clk, reset;
  logic [63:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rlast, rready;
  logic        awvalid, awready, wvalid, wlast, wready, bvalid, bready;

  axi_line_mem #(.BYTES_PER_LINE(BPL), .MEM_LINES(ML)) dut (
    .clk(clk), .reset(reset),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rvalid(rvalid), .s_axi_rlast(rlast), .s_axi_rready(rready),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wvalid(wvalid), .s_axi_wlast(wlast), .s_axi_wready(wready),
    .s_axi_bvalid(bvalid), .s_axi_bready(bready)
  );

  typedef struct {
    logic [63:0] data;
    logic        last;
  } rexp_t;

  rexp_t       rq[$];
  int          bq[$];
  logic [63:0] model [int];
  int          total = 0;
  int          bad = 0;
  rexp_t       mon_e;
  int          mon_b;
  logic        hold_pending = 1'b0;
  logic [63:0] hold_data = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int widx(input logic [63:0] a, input int b);
    return int'((a / BPL) % ML) * NB + b;
  endfunction

  // Monitor: pops expected R beats and B responses when the DUT presents them.
  always @(negedge clk) begin
    if (reset) begin
      if (hold_pending) begin
        check("r_hold_valid", {63'd0, rvalid}, 64'd1);
        check("r_hold_data", rdata, hold_data);
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) begin
          check("r_unexpected", 64'(rq.size()), 64'd1);
        end else begin
          mon_e = rq.pop_front();
          check("rdata", rdata, mon_e.data);
          check("rlast", {63'd0, rlast}, {63'd0, mon_e.last});
        end
      end
      hold_pending = rvalid && !rready;
      hold_data    = rdata;
      if (bvalid && bready) begin
        check("b_expected", 64'(bq.size() != 0), 64'd1);
        if (bq.size() != 0) mon_b = bq.pop_front();
      end
    end else begin
      hold_pending = 1'b0;
    end
  end

  task automatic do_aw(input logic [63:0] addr);
    awaddr  = addr;
    awvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (awready) break;
    end
    check("awready", {63'd0, awready}, 64'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic do_w(input logic [63:0] addr, input int n, input logic [63:0] base);
    int waited;
    for (int i = 0; i < n; i++) begin
      wdata  = base + 64'(i);
      wvalid = 1'b1;
      wlast  = (i == n - 1);
      waited = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (wready) break;
        waited++;
      end
      check("wready", {63'd0, wready}, 64'd1);
      if (i == 0) check("aw_to_wready", 64'(waited), 64'd0);
      @(posedge clk); #1;
      model[widx(addr, i)] = base + 64'(i);
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    bq.push_back(n);
    @(negedge clk);
    check("bvalid_lat", {63'd0, bvalid}, 64'd1);
    check("wready_after_last", {63'd0, wready}, 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic push_read(input logic [63:0] addr);
    rexp_t e;
    for (int b = 0; b < NB; b++) begin
      e.data = model[widx(addr, b)];
      e.last = (b == NB - 1);
      rq.push_back(e);
    end
  endtask

  task automatic do_ar(input logic [63:0] addr);
    push_read(addr);
    araddr  = addr;
    arvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (arready) break;
    end
    check("arready", {63'd0, arready}, 64'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    rready  = 1'b1;
  endtask

  // Drains one read burst; rready dropped for stall_cycles once stall_beat is on the bus.
  task automatic do_r(input int stall_beat, input int stall_cycles, input int abort_after);
    int got, cyc, stalled;
    got = 0; cyc = 0; stalled = 0;
    while (got < NB && cyc < 100) begin
      @(negedge clk);
      if (cyc == 0) check("r_first_lat", {63'd0, rvalid}, 64'd1);
      if (rvalid && rready) got++;
      cyc++;
      @(posedge clk); #1;
      if (got == abort_after) return;
      rready = !(got == stall_beat && stalled < stall_cycles);
      if (!rready) stalled++;
    end
    check("r_beats", 64'(got), 64'(NB));
    check("r_cycles", 64'(cyc), 64'(NB + stall_cycles));
  endtask

  task automatic check_outputs_zero();
    check("rst_arready", {63'd0, arready}, 64'd0);
    check("rst_awready", {63'd0, awready}, 64'd0);
    check("rst_rvalid", {63'd0, rvalid}, 64'd0);
    check("rst_rlast", {63'd0, rlast}, 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_wready", {63'd0, wready}, 64'd0);
    check("rst_bvalid", {63'd0, bvalid}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    #2 reset = 1'b0;
    #1 check_outputs_zero();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Full-line write then streaming readback.
    do_aw(64'h1000);
    do_w(64'h1000, NB, 64'h10);
    do_ar(64'h1000);
    do_r(-1, 0, 99);

    // Back-pressure on beat 2 for three cycles.
    do_ar(64'h1000);
    do_r(2, 3, 99);

    // Partial burst: only words 0..3 of line 0x2000 change.
    do_aw(64'h2000);
    do_w(64'h2000, NB, 64'h20);
    do_aw(64'h2000);
    do_w(64'h2000, 4, 64'hA0);
    do_ar(64'h2000);
    do_r(-1, 0, 99);

    // Reset in the middle of a read with beat 4 on the bus.
    do_ar(64'h1000);
    do_r(-1, 0, 4);
    check("pre_reset_rdata", rdata, model[widx(64'h1000, 4)]);
    reset = 1'b0;
    #1 check_outputs_zero();
    rq.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Both requests after reset: read first, then write; fresh read starts at beat 0.
    push_read(64'h1000);
    araddr = 64'h1000; awaddr = 64'h1000 + 64'(ML * BPL);
    arvalid = 1'b1; awvalid = 1'b1;
    @(negedge clk);
    check("arb1_arready", {63'd0, arready}, 64'd1);
    check("arb1_awready", {63'd0, awready}, 64'd0);
    @(posedge clk); #1;
    arvalid = 1'b0; awvalid = 1'b0; rready = 1'b1;
    do_r(-1, 0, 99);
    arvalid = 1'b1; awvalid = 1'b1;
    @(negedge clk);
    check("arb2_awready", {63'd0, awready}, 64'd1);
    check("arb2_arready", {63'd0, arready}, 64'd0);
    @(posedge clk); #1;
    arvalid = 1'b0; awvalid = 1'b0;
    // Aliased write lands on line 0x1000.
    do_w(64'h1000 + 64'(ML * BPL), NB, 64'h50);
    do_ar(64'h1000);
    do_r(-1, 0, 99);

    repeat (3) @(posedge clk);
    check("r_queue_empty", 64'(rq.size()), 64'd0);
    check("b_queue_empty", 64'(bq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
